id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//   Decode stage of the 5-stage MIPS pipeline; consumes the 64-bit IF_ID register ({PC_Plus4, Instruction}) produced by fetch.
//   Decodes the instruction, reads the external register file, and detects load-use and JR hazards.
//   Drives fetch controls back: IF_Pause, IF_Flush, PCSrc, jump_address, jr_address, exception.
//   Registers the decoded bundle into the ID_EX pipeline register.
// PARAMETERS
//   CTRL_W    12   width of id_ex_ctrl bundle (fields defined in id_pkg)
//   REG_AW    5    register-file address width
// PORTS
//   clk              in   1   pipeline clock, all state on posedge
//   reset            in   1   asynchronous, active-high reset
//   IF_ID            in   64  [63:32] PC_Plus4 (bit31 = kernel mode), [31:0] instruction
//   rf_rs_addr       out  5   register-file read address A = instr[25:21]
//   rf_rt_addr       out  5   register-file read address B = instr[20:16]
//   rf_rs_data       in   32  combinational read data A
//   rf_rt_data       in   32  combinational read data B
//   ex_mem_read      in   1   instruction in EX is a load
//   ex_reg_write     in   1   instruction in EX writes a register
//   ex_dst           in   5   EX destination register
//   ex_alu_result    in   32  EX result (forwarding source)
//   mem_reg_write    in   1   instruction in MEM writes a register
//   mem_dst          in   5   MEM destination register
//   mem_result       in   32  MEM result (forwarding source)
//   ex_branch_taken  in   1   branch resolved taken in EX this cycle
//   IF_Pause         out  1   hold PC and IF_ID
//   IF_Flush         out  1   load NOP into IF_ID at next edge
//   PCSrc            out  3   one-hot {JR, J, B}; 000 = PC+4
//   jump_address     out  32  {IF_ID[63:60], instr[25:0], 2'b00}
//   jr_address       out  32  rs value (forwarded when enabled)
//   exception        out  1   undefined opcode/funct in user mode
//   id_ex_pc4        out  32  registered PC_Plus4
//   id_ex_rs_data    out  32  registered rs operand
//   id_ex_rt_data    out  32  registered rt operand
//   id_ex_imm        out  32  registered extended immediate (sign/zero/LUI per ExtOp)
//   id_ex_rs/rt/rd   out  5   registered register numbers; rd = 31 for JAL
//   id_ex_shamt      out  5   registered shift amount
//   id_ex_ctrl       out  CTRL_W  registered control bundle
// BEHAVIOUR
//   - Reset: all id_ex_* clear to 0 (equivalent to a bubble). Combinational outputs are forced to 0 while reset is high.
//   - Latency: one cycle. Decode is combinational; id_ex_* update on posedge when not held.
//   - Load-use: ex_mem_read & ex_dst!=0 & (ex_dst==rs | (ex_dst==rt & uses_rt)).
//     Response: IF_Pause=1, the ID_EX register takes a bubble (ctrl=0), and IF_ID is held by fetch. Duration is one cycle.
//   - J/JAL: PCSrc=010, IF_Flush=1. JAL writes PC_Plus4 to rd=31 through EX.
//   - JR/JALR: PCSrc=100, IF_Flush=1. A JR hazard (rs is written by EX or MEM) stalls as described under CONFIGURATION.
//   - ex_branch_taken: ID_EX takes a bubble and IF_Flush=1. PCSrc=001 and branch_address are driven by EX; this block's own jump is suppressed.
//   - Priority: ex_branch_taken > load-use/JR stall > J/JR > PC+4.
//   - Stall and jump never coincide: PCSrc=000 whenever IF_Pause=1.
//   - Register $0 never matches in any hazard compare.
//   - exception: raised only when IF_ID[63]==0. An all-zero instruction is a NOP (sll $0) and decodes legally.
//   - Reset mid-stall: the stall aborts; the pipeline restarts from the bubble state.
// CONFIGURATION
//   ID_JR_FORWARD_EN defined:
//     - jr_address and id_ex_rs_data/rt_data are forwarded: EX result first, then MEM result.
//     - JR stalls only when the EX instruction is a load (1 cycle).
//   ID_JR_FORWARD_EN undefined:
//     - No forwarding in ID.
//     - JR stalls while EX or MEM writes rs (up to 2 cycles).
//     - Operands are taken raw from the register file; EX performs the forwarding.
// STRUCTURE
//   - id_pkg: opcode/funct constants, CTRL_W bit indices (RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst[1:0], ExtOp[1:0], ALUOp[2:0]), NOP ctrl = 0.
//   - Sub-module id_ctrl_decode: purely combinational map from opcode/funct to ctrl bundle, legal flag, and uses_rt.
// TESTING
//   1. Reset asserted mid-stall -> id_ex_ctrl=0, IF_Pause=0, PCSrc=000 immediately; restart clean.
//   2. EX=lw $8 (ex_mem_read=1, ex_dst=8), ID=add $9,$8,$10 -> IF_Pause=1 one cycle, bubble in ID_EX, add issues next cycle.
//   3. IF_ID={32'h0040_0004, j 0x0100004} -> PCSrc=010, jump_address=32'h0040_0010, IF_Flush=1.
//   4. jal with PC_Plus4=32'h0040_0020 -> id_ex_rd=31, id_ex_pc4=32'h0040_0020, RegWrite=1.
//   5. jr $31, EX writes $31 = 32'h0040_0100 -> with macro: jr_address=32'h0040_0100, no stall. Without macro: 2 stall cycles, then the register-file value is used.
//   6. ex_branch_taken=1 while a load-use hazard is present -> IF_Flush=1, IF_Pause=0, bubble in ID_EX.

Source files
------------

// File: rtl/id_pkg.sv
`default_nettype none
// id_pkg: opcode/funct constants, control-bundle layout and encodings for the MIPS decode stage.
// Rev 1.0
package id_pkg;

  localparam int ID_CTRL_W = 12;
  localparam int ID_REG_AW = 5;

  // Control bundle layout: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst[1:0], ExtOp[1:0], ALUOp[2:0]}
  localparam int C_REG_WRITE  = 11;
  localparam int C_MEM_READ   = 10;
  localparam int C_MEM_WRITE  = 9;
  localparam int C_MEM_TO_REG = 8;
  localparam int C_ALU_SRC    = 7;
  localparam int C_REG_DST_LO = 5;
  localparam int C_EXT_OP_LO  = 3;
  localparam int C_ALU_OP_LO  = 0;

  localparam logic [ID_CTRL_W-1:0] CTRL_NOP = '0;

  typedef enum logic [1:0] {DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10} reg_dst_e;
  typedef enum logic [1:0] {EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_LUI = 2'b10} ext_op_e;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_RTYPE = 3'b010, ALU_AND = 3'b011,
    ALU_OR  = 3'b100, ALU_XOR = 3'b101, ALU_SLT   = 3'b110, ALU_SLTU = 3'b111
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c, OP_ORI   = 6'h0d, OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f, OP_LW    = 6'h23, OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27, FN_SLT  = 6'h2a, FN_SLTU = 6'h2b;

  function automatic logic [ID_CTRL_W-1:0] make_ctrl(
    input logic rw, input logic mr, input logic mw, input logic m2r, input logic src,
    input reg_dst_e dst, input ext_op_e ext, input alu_op_e alu);
    return {rw, mr, mw, m2r, src, dst, ext, alu};
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ctrl_decode.sv
`default_nettype none
// id_ctrl_decode: combinational opcode/funct to control bundle, legality and operand-use map.
// Rev 1.0
module id_ctrl_decode
  import id_pkg::*;
(
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  output logic [ID_CTRL_W-1:0] ctrl,
  output logic                 legal,
  output logic                 uses_rt,
  output logic                 is_j,
  output logic                 is_jr
);

  always_comb begin
    ctrl    = CTRL_NOP;
    legal   = 1'b1;
    uses_rt = 1'b0;
    is_j    = 1'b0;
    is_jr   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            uses_rt = 1'b1;
            ctrl = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DST_RD, EXT_ZERO, ALU_RTYPE);
          end
          FN_JR:   is_jr = 1'b1;
          FN_JALR: begin
            is_jr = 1'b1;
            ctrl = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DST_RD, EXT_ZERO, ALU_ADD);
          end
          default: legal = 1'b0;
        endcase
      end
      OP_J:   is_j = 1'b1;
      OP_JAL: begin
        is_j = 1'b1;
        ctrl = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DST_RA, EXT_ZERO, ALU_ADD);
      end
      OP_BEQ, OP_BNE: begin
        uses_rt = 1'b1;
        ctrl = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DST_RT, EXT_SIGN, ALU_SUB);
      end
      OP_ADDI, OP_ADDIU: ctrl = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DST_RT, EXT_SIGN, ALU_ADD);
      OP_SLTI:  ctrl = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DST_RT, EXT_SIGN, ALU_SLT);
      OP_SLTIU: ctrl = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DST_RT, EXT_SIGN, ALU_SLTU);
      OP_ANDI:  ctrl = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DST_RT, EXT_ZERO, ALU_AND);
      OP_ORI:   ctrl = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DST_RT, EXT_ZERO, ALU_OR);
      OP_XORI:  ctrl = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DST_RT, EXT_ZERO, ALU_XOR);
      OP_LUI:   ctrl = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DST_RT, EXT_LUI, ALU_ADD);
      OP_LW:    ctrl = make_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, DST_RT, EXT_SIGN, ALU_ADD);
      OP_SW: begin
        uses_rt = 1'b1;
        ctrl = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, DST_RT, EXT_SIGN, ALU_ADD);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// id_stage: MIPS decode stage with load-use/JR hazard detection, fetch redirect and ID_EX register.
// Optional macro ID_JR_FORWARD_EN: forward EX/MEM results into ID (JR stalls only behind a load). Rev 1.0
module id_stage
  import id_pkg::*;
#(
  parameter int CTRL_W = ID_CTRL_W,
  parameter int REG_AW = ID_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       IF_ID,
  output logic [REG_AW-1:0] rf_rs_addr,
  output logic [REG_AW-1:0] rf_rt_addr,
  input  logic [31:0]       rf_rs_data,
  input  logic [31:0]       rf_rt_data,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic [31:0]       ex_alu_result,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic [31:0]       mem_result,
  input  logic              ex_branch_taken,
  output logic              IF_Pause,
  output logic              IF_Flush,
  output logic [2:0]        PCSrc,
  output logic [31:0]       jump_address,
  output logic [31:0]       jr_address,
  output logic              exception,
  output logic [31:0]       id_ex_pc4,
  output logic [31:0]       id_ex_rs_data,
  output logic [31:0]       id_ex_rt_data,
  output logic [31:0]       id_ex_imm,
  output logic [REG_AW-1:0] id_ex_rs,
  output logic [REG_AW-1:0] id_ex_rt,
  output logic [REG_AW-1:0] id_ex_rd,
  output logic [4:0]        id_ex_shamt,
  output logic [CTRL_W-1:0] id_ex_ctrl
);

  logic [31:0]       pc4, instr, rs_val, rt_val, imm_ext;
  logic [REG_AW-1:0] rs, rt, rd, dst_rd;
  logic [CTRL_W-1:0] ctrl;
  logic              legal, uses_rt, is_j, is_jr;
  logic              load_use, jr_stall, stall, bubble;

  assign pc4   = IF_ID[63:32];
  assign instr = IF_ID[31:0];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];

  id_ctrl_decode u_dec (
    .opcode  (instr[31:26]),
    .funct   (instr[5:0]),
    .ctrl    (ctrl),
    .legal   (legal),
    .uses_rt (uses_rt),
    .is_j    (is_j),
    .is_jr   (is_jr)
  );

  assign load_use = ex_mem_read && (ex_dst != '0) &&
                    ((ex_dst == rs) || ((ex_dst == rt) && uses_rt));

`ifdef ID_JR_FORWARD_EN
  logic rs_ex_hit, rs_mem_hit, rt_ex_hit, rt_mem_hit;
  assign rs_ex_hit  = (rs != '0) && ex_reg_write  && (ex_dst  == rs);
  assign rs_mem_hit = (rs != '0) && mem_reg_write && (mem_dst == rs);
  assign rt_ex_hit  = (rt != '0) && ex_reg_write  && (ex_dst  == rt);
  assign rt_mem_hit = (rt != '0) && mem_reg_write && (mem_dst == rt);
  assign rs_val = rs_ex_hit ? ex_alu_result : (rs_mem_hit ? mem_result : rf_rs_data);
  assign rt_val = rt_ex_hit ? ex_alu_result : (rt_mem_hit ? mem_result : rf_rt_data);
  // A load result is not available until after MEM, so only that case still stalls.
  assign jr_stall = is_jr && ex_mem_read && (ex_dst != '0) && (ex_dst == rs);
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_alu_result, mem_result};
  assign rs_val = rf_rs_data;
  assign rt_val = rf_rt_data;
  assign jr_stall = is_jr && (rs != '0) &&
                    ((ex_reg_write && (ex_dst == rs)) || (mem_reg_write && (mem_dst == rs)));
`endif

  // A taken branch in EX kills this instruction, so it overrides any stall.
  assign stall  = (load_use || jr_stall) && !ex_branch_taken;
  assign bubble = stall || ex_branch_taken;

  assign IF_Pause     = !reset && stall;
  assign IF_Flush     = !reset && (ex_branch_taken || (!stall && (is_j || is_jr)));
  assign PCSrc        = (reset || bubble) ? 3'b000 : {is_jr, is_j, 1'b0};
  assign jump_address = reset ? '0 : {pc4[31:28], instr[25:0], 2'b00};
  assign jr_address   = reset ? '0 : rs_val;
  assign exception    = !reset && !legal && !pc4[31];
  assign rf_rs_addr   = reset ? '0 : rs;
  assign rf_rt_addr   = reset ? '0 : rt;

  always_comb begin
    imm_ext = {16'h0000, instr[15:0]};
    case (ext_op_e'(ctrl[C_EXT_OP_LO +: 2]))
      EXT_SIGN: imm_ext = {{16{instr[15]}}, instr[15:0]};
      EXT_LUI:  imm_ext = {instr[15:0], 16'h0000};
      default:  imm_ext = {16'h0000, instr[15:0]};
    endcase
  end

  assign dst_rd = (reg_dst_e'(ctrl[C_REG_DST_LO +: 2]) == DST_RA) ? REG_AW'(31) : rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || bubble) begin
      id_ex_pc4     <= '0;
      id_ex_rs_data <= '0;
      id_ex_rt_data <= '0;
      id_ex_imm     <= '0;
      id_ex_rs      <= '0;
      id_ex_rt      <= '0;
      id_ex_rd      <= '0;
      id_ex_shamt   <= '0;
      id_ex_ctrl    <= '0;
    end else begin
      id_ex_pc4     <= pc4;
      id_ex_rs_data <= rs_val;
      id_ex_rt_data <= rt_val;
      id_ex_imm     <= imm_ext;
      id_ex_rs      <= rs;
      id_ex_rt      <= rt;
      id_ex_rd      <= dst_rd;
      id_ex_shamt   <= instr[10:6];
      id_ex_ctrl    <= ctrl;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// tb_id_stage: table-driven decode/hazard vectors plus directed multi-cycle sequences for id_stage.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] IF_ID = '0;
  logic [4:0]  rf_rs_addr, rf_rt_addr;
  logic [31:0] rf_rs_data = 32'hAAAA0001, rf_rt_data = 32'hBBBB0002;
  logic        ex_mem_read = 1'b0, ex_reg_write = 1'b0;
  logic [4:0]  ex_dst = '0;
  logic [31:0] ex_alu_result = 32'hE0E0E0E0;
  logic        mem_reg_write = 1'b0;
  logic [4:0]  mem_dst = '0;
  logic [31:0] mem_result = 32'h30303030;
  logic        ex_branch_taken = 1'b0;
  logic        IF_Pause, IF_Flush, exception;
  logic [2:0]  PCSrc;
  logic [31:0] jump_address, jr_address, id_ex_pc4, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt;
  logic [11:0] id_ex_ctrl;

  int errors = 0;
  int checks = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .IF_ID(IF_ID),
    .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
    .ex_alu_result(ex_alu_result), .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
    .mem_result(mem_result), .ex_branch_taken(ex_branch_taken),
    .IF_Pause(IF_Pause), .IF_Flush(IF_Flush), .PCSrc(PCSrc),
    .jump_address(jump_address), .jr_address(jr_address), .exception(exception),
    .id_ex_pc4(id_ex_pc4), .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
    .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_shamt(id_ex_shamt), .id_ex_ctrl(id_ex_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        exmr;
    logic        exrw;
    logic [4:0]  exdst;
    logic        br;
    logic        pause;
    logic        flush;
    logic [2:0]  pcsrc;
    logic        exc;
    logic [11:0] ctrl;
    logic [31:0] imm;
  } vec_t;

  localparam int NV = 22;
  vec_t vec[NV];

  function automatic vec_t mk(input logic [31:0] pc4, input logic [31:0] instr,
                              input logic exmr, input logic exrw, input logic [4:0] exdst,
                              input logic br, input logic pause, input logic flush,
                              input logic [2:0] pcsrc, input logic exc,
                              input logic [11:0] ctrl, input logic [31:0] imm);
    vec_t v;
    v.pc4 = pc4; v.instr = instr; v.exmr = exmr; v.exrw = exrw; v.exdst = exdst; v.br = br;
    v.pause = pause; v.flush = flush; v.pcsrc = pcsrc; v.exc = exc; v.ctrl = ctrl; v.imm = imm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [31:0] PC  = 32'h0040_0004;
  localparam logic [31:0] ADD = 32'h010A_4820;  // add $9,$8,$10

  initial begin
    vec[0]  = mk(PC, ADD,          0, 0, 0,  0, 0, 0, 3'b000, 0, 12'h822, 32'h0000_4820);
    vec[1]  = mk(PC, 32'h0,        0, 0, 0,  0, 0, 0, 3'b000, 0, 12'h822, 32'h0);
    vec[2]  = mk(PC, 32'h8D28_0004, 0, 0, 0, 0, 0, 0, 3'b000, 0, 12'hD88, 32'h4);
    vec[3]  = mk(PC, 32'hACC5_0008, 0, 0, 0, 0, 0, 0, 3'b000, 0, 12'h288, 32'h8);
    vec[4]  = mk(PC, 32'h2062_FFFF, 0, 0, 0, 0, 0, 0, 3'b000, 0, 12'h888, 32'hFFFF_FFFF);
    vec[5]  = mk(PC, 32'h3462_8000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 12'h884, 32'h0000_8000);
    vec[6]  = mk(PC, 32'h3C04_1234, 0, 0, 0, 0, 0, 0, 3'b000, 0, 12'h890, 32'h1234_0000);
    vec[7]  = mk(PC, 32'h1022_0003, 0, 0, 0, 0, 0, 0, 3'b000, 0, 12'h009, 32'h3);
    vec[8]  = mk(PC, 32'h0810_0004, 0, 0, 0, 0, 0, 1, 3'b010, 0, 12'h000, 32'h4);
    vec[9]  = mk(PC, 32'h03E0_0008, 0, 0, 0, 0, 0, 1, 3'b100, 0, 12'h000, 32'h8);
    vec[10] = mk(PC, 32'hFC00_0000, 0, 0, 0, 0, 0, 0, 3'b000, 1, 12'h000, 32'h0);
    vec[11] = mk(32'h8000_0004, 32'hFC00_0000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 12'h000, 32'h0);
    vec[12] = mk(PC, 32'h0000_003F, 0, 0, 0, 0, 0, 0, 3'b000, 1, 12'h000, 32'h3F);
    vec[13] = mk(PC, ADD,          1, 1, 8,  0, 1, 0, 3'b000, 0, 12'h000, 32'h0);
    vec[14] = mk(PC, ADD,          1, 1, 10, 0, 1, 0, 3'b000, 0, 12'h000, 32'h0);
    vec[15] = mk(PC, 32'h2062_FFFF, 1, 1, 2, 0, 0, 0, 3'b000, 0, 12'h888, 32'hFFFF_FFFF);
    vec[16] = mk(PC, 32'h3C04_1234, 1, 1, 0, 0, 0, 0, 3'b000, 0, 12'h890, 32'h1234_0000);
    vec[17] = mk(PC, ADD,          0, 1, 8,  0, 0, 0, 3'b000, 0, 12'h822, 32'h0000_4820);
    vec[18] = mk(PC, ADD,          1, 1, 8,  1, 0, 1, 3'b000, 0, 12'h000, 32'h0);
    vec[19] = mk(PC, 32'h0810_0004, 0, 0, 0, 1, 0, 1, 3'b000, 0, 12'h000, 32'h0);
    vec[20] = mk(PC, 32'h03E0_0008, 1, 1, 31, 0, 1, 0, 3'b000, 0, 12'h000, 32'h0);
    vec[21] = mk(PC, 32'hACC5_0008, 1, 1, 5, 0, 1, 0, 3'b000, 0, 12'h000, 32'h0);

    // Outputs held quiet while reset is high, even with a hazard and a jump present.
    IF_ID = {PC, 32'h0810_0004}; ex_mem_read = 1'b1; ex_dst = 5'd0;
    #2;
    chk("reset pcsrc", PCSrc, 3'b000);
    chk("reset flush", IF_Flush, 1'b0);
    IF_ID = {PC, ADD}; ex_dst = 5'd8;
    #1;
    chk("reset pause", IF_Pause, 1'b0);
    chk("reset ctrl", id_ex_ctrl, 12'h000);
    @(negedge clk); reset = 1'b0; ex_mem_read = 1'b0; ex_dst = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      IF_ID = {vec[i].pc4, vec[i].instr};
      ex_mem_read = vec[i].exmr; ex_reg_write = vec[i].exrw;
      ex_dst = vec[i].exdst; ex_branch_taken = vec[i].br;
      #1;
      chk($sformatf("v%0d pause", i), IF_Pause, vec[i].pause);
      chk($sformatf("v%0d flush", i), IF_Flush, vec[i].flush);
      chk($sformatf("v%0d pcsrc", i), PCSrc, vec[i].pcsrc);
      chk($sformatf("v%0d exception", i), exception, vec[i].exc);
      @(posedge clk); #1;
      chk($sformatf("v%0d ctrl", i), id_ex_ctrl, vec[i].ctrl);
      chk($sformatf("v%0d imm", i), id_ex_imm, vec[i].imm);
    end
    @(negedge clk);
    ex_mem_read = 0; ex_reg_write = 0; ex_dst = 0; ex_branch_taken = 0;

    // Jump target and J-type operand fields.
    IF_ID = {PC, 32'h0810_0004};
    #1;
    chk("j jump_address", jump_address, 32'h0040_0010);

    // Reset asserted in the middle of a load-use stall.
    @(negedge clk); IF_ID = {PC, ADD};
    @(posedge clk); #1;
    chk("pre-stall ctrl", id_ex_ctrl, 12'h822);
    @(negedge clk); ex_mem_read = 1; ex_reg_write = 1; ex_dst = 8;
    #1;
    chk("mid-stall pause", IF_Pause, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("mid-stall reset ctrl", id_ex_ctrl, 12'h000);
    chk("mid-stall reset pause", IF_Pause, 1'b0);
    chk("mid-stall reset pcsrc", PCSrc, 3'b000);
    @(negedge clk); reset = 1'b0; ex_mem_read = 0; ex_reg_write = 0; ex_dst = 0;
    @(posedge clk); #1;
    chk("restart ctrl", id_ex_ctrl, 12'h822);

    // Load-use: one stall cycle, bubble, then the add issues with the load now in MEM.
    @(negedge clk); ex_mem_read = 1; ex_reg_write = 1; ex_dst = 8;
    #1;
    chk("lu pause c1", IF_Pause, 1'b1);
    @(posedge clk); #1;
    chk("lu bubble ctrl", id_ex_ctrl, 12'h000);
    @(negedge clk); ex_mem_read = 0; ex_reg_write = 0; ex_dst = 0;
    mem_reg_write = 1; mem_dst = 8; mem_result = 32'h1234_5678;
    #1;
    chk("lu pause c2", IF_Pause, 1'b0);
    @(posedge clk); #1;
    chk("lu issue ctrl", id_ex_ctrl, 12'h822);
`ifdef ID_JR_FORWARD_EN
    chk("lu rs_data", id_ex_rs_data, 32'h1234_5678);
`else
    chk("lu rs_data", id_ex_rs_data, 32'hAAAA_0001);
`endif
    @(negedge clk); mem_reg_write = 0; mem_dst = 0;

    // JAL writes PC_Plus4 into $31.
    IF_ID = {32'h0040_0020, 32'h0C10_0004};
    #1;
    chk("jal pcsrc", PCSrc, 3'b010);
    chk("jal jump_address", jump_address, 32'h0040_0010);
    chk("jal flush", IF_Flush, 1'b1);
    @(posedge clk); #1;
    chk("jal rd", id_ex_rd, 5'd31);
    chk("jal pc4", id_ex_pc4, 32'h0040_0020);
    chk("jal regwrite", id_ex_ctrl[11], 1'b1);

    // JR $31 while EX writes $31.
    @(negedge clk);
    IF_ID = {PC, 32'h03E0_0008}; rf_rs_data = 32'h1111_1111;
    ex_reg_write = 1; ex_dst = 31; ex_alu_result = 32'h0040_0100;
`ifdef ID_JR_FORWARD_EN
    #1;
    chk("jr fwd pause", IF_Pause, 1'b0);
    chk("jr fwd pcsrc", PCSrc, 3'b100);
    chk("jr fwd address", jr_address, 32'h0040_0100);
    mem_reg_write = 1; mem_dst = 31; mem_result = 32'h2222_2222;
    #1;
    chk("jr fwd ex priority", jr_address, 32'h0040_0100);
    ex_reg_write = 0;
    #1;
    chk("jr fwd mem", jr_address, 32'h2222_2222);
`else
    #1;
    chk("jr stall c1 pause", IF_Pause, 1'b1);
    chk("jr stall c1 pcsrc", PCSrc, 3'b000);
    @(posedge clk); #1;
    chk("jr stall bubble", id_ex_ctrl, 12'h000);
    @(negedge clk); ex_reg_write = 0; ex_dst = 0; mem_reg_write = 1; mem_dst = 31;
    #1;
    chk("jr stall c2 pause", IF_Pause, 1'b1);
    chk("jr stall c2 pcsrc", PCSrc, 3'b000);
    @(negedge clk); mem_reg_write = 0; mem_dst = 0; rf_rs_data = 32'h0040_0100;
    #1;
    chk("jr resume pause", IF_Pause, 1'b0);
    chk("jr resume pcsrc", PCSrc, 3'b100);
    chk("jr resume flush", IF_Flush, 1'b1);
    chk("jr resume address", jr_address, 32'h0040_0100);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
